// File: rtl/beat_responder.sv
// rtl/beat_responder.sv - responder half of the beat protocol
// Runs one beat per accepted strobe, fetches/decodes IR and returns a done pulse per beat.
module beat_responder #(
  parameter int DW     = 16,
  parameter int EX_LAT = 2,
  parameter int MEM_TO = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          Mif,
  input  logic          Mex,
  input  logic          T1,
  input  logic          T2,
  input  logic          T3,
  input  logic          T4,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_req,
  output logic          mem_op,
  output logic          done,
  output logic [1:0]    cnt_set,
  output logic          stop,
  output logic [DW-1:0] ir,
  output logic          beat_err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] MEMW  = 2'd1;
  localparam logic [1:0] COUNT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0] state;
  logic [7:0] cnt;
  logic       beat_mif;
  logic       beat_mex;
  logic [1:0] beat_t;

  logic [2:0] t_sum;
  logic       any_t;
  logic       strobe_ok;
  logic       strobe_bad;
  logic [1:0] t_idx;
  logic [3:0] ir_op;
  logic       ir_mem;
  logic       beat_is_if2;

  function automatic logic op_is_mem(input logic [3:0] op);
    return (op >= 4'h8) && (op <= 4'hE);
  endfunction

  assign t_sum       = {2'b00, T1} + {2'b00, T2} + {2'b00, T3} + {2'b00, T4};
  assign any_t       = (t_sum != 3'd0);
  assign strobe_ok   = (state == IDLE) && (t_sum == 3'd1) && (Mif != Mex);
  assign strobe_bad  = any_t && !strobe_ok;
  assign t_idx       = T2 ? 2'd1 : (T3 ? 2'd2 : (T4 ? 2'd3 : 2'd0));
  assign ir_op       = ir[DW-1:DW-4];
  assign ir_mem      = op_is_mem(ir_op);
  assign beat_is_if2 = beat_mif && !beat_mex && (beat_t == 2'd1);

  // Request and done come straight from state flops so reset kills them at once.
  assign mem_req = (state == MEMW);
  assign done    = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 8'd0;
      beat_mif <= 1'b0;
      beat_mex <= 1'b0;
      beat_t   <= 2'd0;
      mem_op   <= 1'b0;
      cnt_set  <= 2'd0;
      stop     <= 1'b0;
      ir       <= '0;
      beat_err <= 1'b0;
    end else begin
      if (strobe_bad) begin
        beat_err <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (strobe_ok) begin
            beat_mif <= Mif;
            beat_mex <= Mex;
            beat_t   <= t_idx;
            if (Mif && T1) begin
              state  <= MEMW;
              mem_op <= 1'b0;
              cnt    <= 8'd1;
              stop   <= 1'b0;
            end else if (Mex && T2 && ir_mem) begin
              state  <= MEMW;
              mem_op <= 1'b1;
              cnt    <= 8'd1;
            end else if (Mex) begin
              state <= COUNT;
              cnt   <= 8'(EX_LAT);
            end else begin
              state <= COUNT;
              cnt   <= 8'd1;
            end
          end
        end
        MEMW: begin
          // cnt holds the index of the current request cycle.
          if (mem_ack) begin
            state <= DONE;
            if (!mem_op) begin
              ir <= mem_rdata;
            end
          end else if (cnt == 8'(MEM_TO)) begin
            state    <= DONE;
            beat_err <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        COUNT: begin
          if (cnt <= 8'd1) begin
            state <= DONE;
            // Decode lands together with the IF2 done pulse.
            if (beat_is_if2) begin
              cnt_set <= ir_mem ? 2'd3 : 2'd0;
              stop    <= (ir_op == 4'hF);
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_beat_responder.sv
// tb/tb_beat_responder.sv - randomized self-checking bench for beat_responder
// Expected beat timing and register contents come from a per-beat arithmetic model.
module tb_beat_responder;
  localparam int EX_LAT = 2;
  localparam int MEM_TO = 15;

  logic        clk;
  logic        rst;
  logic        Mif, Mex, T1, T2, T3, T4;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        mem_req, mem_op, done, stop, beat_err;
  logic [1:0]  cnt_set;
  logic [15:0] ir;

  int total = 0;
  int bad   = 0;

  logic [15:0] ir_m;
  logic [1:0]  cnt_m;
  logic        stop_m;
  logic        err_m;

  beat_responder #(.DW(16), .EX_LAT(EX_LAT), .MEM_TO(MEM_TO)) dut (
    .clk(clk), .rst(rst), .Mif(Mif), .Mex(Mex),
    .T1(T1), .T2(T2), .T3(T3), .T4(T4),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mem_req(mem_req), .mem_op(mem_op), .done(done),
    .cnt_set(cnt_set), .stop(stop), .ir(ir), .beat_err(beat_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op >= 4'h8) && (op <= 4'hE);
  endfunction

  task automatic drive_t(input int tn);
    T1 = (tn == 1);
    T2 = (tn == 2);
    T3 = (tn == 3);
    T4 = (tn == 4);
  endtask

  task automatic model_reset();
    ir_m = 16'h0; cnt_m = 2'd0; stop_m = 1'b0; err_m = 1'b0;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, ".mem_req"}, mem_req, 0);
    chk({tag, ".mem_op"}, mem_op, 0);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".cnt_set"}, cnt_set, 0);
    chk({tag, ".stop"}, stop, 0);
    chk({tag, ".ir"}, ir, 0);
    chk({tag, ".beat_err"}, beat_err, 0);
  endtask

  // One beat: strobe, optional ack at request cycle ack_at (0 = never), optional T3 at cycle inj_k.
  task automatic do_beat(input logic mif, input logic mex, input int tn,
                         input int ack_at, input logic [15:0] rd, input int inj_k);
    logic        is_mem, tmo;
    int          exp_req, exp_lat, k, done_at, req_n, op_bad;
    logic [15:0] ir_at;
    logic [1:0]  cs_at;
    logic        st_at, er_at;
    is_mem = (mif && tn == 1) || (mex && tn == 2 && is_mem_op(ir_m[15:12]));
    tmo = 1'b0;
    if (is_mem) begin
      if (ack_at >= 1 && ack_at <= MEM_TO) begin
        exp_req = ack_at; exp_lat = ack_at + 1;
      end else begin
        exp_req = MEM_TO; exp_lat = MEM_TO + 1; tmo = 1'b1;
      end
    end else begin
      exp_req = 0;
      exp_lat = mex ? EX_LAT + 1 : 2;
    end
    if (mif && tn == 1) stop_m = 1'b0;
    if (is_mem && !tmo && !mex) ir_m = rd;
    if (tmo || inj_k > 0) err_m = 1'b1;
    if (mif && tn == 2) begin
      cnt_m  = is_mem_op(ir_m[15:12]) ? 2'd3 : 2'd0;
      stop_m = (ir_m[15:12] == 4'hF);
    end

    @(negedge clk);
    Mif = mif; Mex = mex; drive_t(tn);
    @(negedge clk);
    drive_t(0);
    k = 1; done_at = 0; req_n = 0; op_bad = 0;
    ir_at = 16'h0; cs_at = 2'd0; st_at = 1'b0; er_at = 1'b0;
    while (done_at == 0 && k <= 100) begin
      if (mem_req) begin
        req_n++;
        if (mem_op !== mex) op_bad++;
      end
      if (done) begin
        done_at = k; ir_at = ir; cs_at = cnt_set; st_at = stop; er_at = beat_err;
      end
      mem_ack   = (k == ack_at);
      mem_rdata = (k == ack_at) ? rd : 16'($urandom);
      if (k == inj_k) T3 = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0; T3 = 1'b0;
      k++;
    end
    chk("latency", done_at, exp_lat);
    chk("req_cycles", req_n, exp_req);
    chk("mem_op", op_bad, 0);
    chk("ir", ir_at, ir_m);
    chk("cnt_set", cs_at, cnt_m);
    chk("stop", st_at, stop_m);
    chk("beat_err", er_at, err_m);
    chk("done_single", done, 0);
  endtask

  task automatic run_instr(input logic [15:0] word, input int ack_if, input int ack_ex);
    do_beat(1'b1, 1'b0, 1, ack_if, word, 0);
    do_beat(1'b1, 1'b0, 2, 1, 16'($urandom), 0);
    if (!stop_m) begin
      do_beat(1'b0, 1'b1, 1, 1, 16'($urandom), 0);
      if (cnt_m == 2'd3) begin
        do_beat(1'b0, 1'b1, 2, ack_ex, 16'($urandom), 0);
        do_beat(1'b0, 1'b1, 3, 0, 16'h0, ($urandom_range(0, 9) == 0) ? 1 : 0);
        do_beat(1'b0, 1'b1, 4, 0, 16'h0, 0);
      end
    end
  endtask

  task automatic idle_strobe_bad(input logic mif, input logic mex, input int tn_a, input int tn_b);
    int act;
    @(negedge clk);
    Mif = mif; Mex = mex; drive_t(tn_a);
    if (tn_b == 2) T2 = 1'b1;
    act = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive_t(0);
      if (done || mem_req) act++;
    end
    chk("bad_strobe_ignored", act, 0);
    chk("bad_strobe_err", beat_err, 1);
    err_m = 1'b1;
  endtask

  task automatic reset_mid_memw();
    int dn;
    @(negedge clk);
    Mif = 1'b1; Mex = 1'b0; drive_t(1);
    @(negedge clk);
    drive_t(0);
    @(negedge clk);
    chk("pre_reset_req", mem_req, 1);
    #2 rst = 1'b1;
    #1;
    chk("reset_req_async", mem_req, 0);
    dn = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) dn++;
    end
    rst = 1'b0;
    chk("reset_no_done", dn, 0);
    model_reset();
    @(negedge clk);
    chk_outputs_zero("after_reset");
  endtask

  initial begin
    logic [15:0] w;
    int          a_if, a_ex;
    rst = 1'b1; Mif = 0; Mex = 0; T1 = 0; T2 = 0; T3 = 0; T4 = 0;
    mem_ack = 0; mem_rdata = 16'h0;
    model_reset();
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    rst = 1'b0;

    // Fetch ALU, then memory op, then HALT.
    run_instr(16'h1234, 3, 2);
    run_instr(16'h8ABC, 2, 2);
    run_instr(16'hF000, 1, 1);
    repeat (3) @(negedge clk);
    chk("stop_held", stop, 1);
    run_instr(16'h0000, 1, 1);

    // Fetch timeout boundary: ack in the last allowed cycle, then no ack at all.
    do_beat(1'b1, 1'b0, 1, MEM_TO, 16'h2222, 0);
    chk("no_err_at_last_cycle", beat_err, 0);
    do_beat(1'b1, 1'b0, 1, 0, 16'h3333, 0);

    reset_mid_memw();
    run_instr(16'h9001, 1, 4);

    // Strobe during MEMW: flagged, beat still completes once.
    do_beat(1'b1, 1'b0, 1, 4, 16'h7777, 1);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    idle_strobe_bad(1'b1, 1'b0, 1, 2);
    idle_strobe_bad(1'b0, 1'b0, 1, 0);
    idle_strobe_bad(1'b1, 1'b1, 3, 0);
    run_instr(16'h5555, 2, 1);

    for (int n = 0; n < 30; n++) begin
      w = 16'($urandom);
      case ($urandom_range(0, 9))
        0:       a_if = 0;
        1:       a_if = MEM_TO;
        default: a_if = $urandom_range(1, 6);
      endcase
      a_ex = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 5);
      run_instr(w, a_if, a_ex);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
